// File: rtl/config_loader.sv
// config_loader: serialises parallel words into the config chain, LSB first, exactly CHAIN_LEN bits.
// Optional CRC-16-CCITT check word after the image when CONFIG_CRC_EN is defined.
module config_loader #(
  parameter int CHAIN_LEN = 260,
  parameter int WORD_W = 32,
  parameter int CNT_W = 9
) (
  input  logic              config_clk,
  input  logic              config_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              chain_out,
  output logic              chain_en,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int NB_W = $clog2(WORD_W + 1);
`ifdef CONFIG_CRC_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif
  state_t state, state_nx;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [NB_W-1:0] nbits, nb_load;
  logic [CNT_W:0] cnt_nx;
  logic [31:0] rem;
  logic idle_start, fin, refill, hs;
  assign idle_start = (state == IDLE || state == DONE) && start;
  assign cnt_nx = {1'b0, bit_cnt} + 1'b1;
  assign fin = state == SHIFT && cnt_nx == (CNT_W + 1)'(CHAIN_LEN);
  assign refill = state == SHIFT && nbits == NB_W'(1) && !fin;
  // bits still owed to the chain once the current cycle's shift (if any) is done
  assign rem = 32'(CHAIN_LEN) - 32'(state == SHIFT ? cnt_nx : {1'b0, bit_cnt});
  assign nb_load = rem > 32'(WORD_W) ? NB_W'(WORD_W) : NB_W'(rem);
  assign chain_en = state == SHIFT;
  assign chain_out = chain_en & shreg[0];
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
`ifdef CONFIG_CRC_EN
  assign in_ready = state == LOAD || refill || state == CHECK;
`else
  assign in_ready = state == LOAD || refill;
`endif
  assign hs = in_valid & in_ready;
  always_comb begin
    state_nx = state;
    if (idle_start) state_nx = LOAD;
    else if (state == LOAD && in_valid) state_nx = SHIFT;
`ifdef CONFIG_CRC_EN
    else if (fin) state_nx = CHECK;
    else if (state == CHECK && in_valid) state_nx = DONE;
`else
    else if (fin) state_nx = DONE;
`endif
    else if (refill && !in_valid) state_nx = LOAD;
  end
  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      nbits <= '0;
    end else begin
      state <= state_nx;
      if (idle_start) bit_cnt <= '0;
      else if (chain_en) bit_cnt <= cnt_nx[CNT_W-1:0];
      if (hs) begin
        shreg <= in_data;
        nbits <= nb_load;
      end else if (chain_en) begin
        shreg <= shreg >> 1;
        nbits <= nbits - NB_W'(1);
      end
    end
  end
`ifdef CONFIG_CRC_EN
  logic [15:0] crc;
  logic fb;
  assign fb = crc[15] ^ chain_out;
  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) begin
      crc <= 16'hFFFF;
      error <= 1'b0;
    end else if (idle_start) begin
      crc <= 16'hFFFF;
      error <= 1'b0;
    end else begin
      if (chain_en) crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      if (state == CHECK && in_valid) error <= crc != in_data[15:0];
    end
  end
`else
  assign error = 1'b0;
`endif
endmodule
